i2s_codec_slave: RTL and testbench

Codec-side (responder) end of the 16-bit audio serial link driven by the audio codec master. It does not generate clocks. It follows externally supplied BCLK/LRCK, deserialises DACDAT into left/right words, and serialises ADC words back onto ADCDAT. It serves as an on-FPGA codec stand-in for loopback/self-test and as a slave port toward an external clock master.

---
 rtl/audio_pkg.sv | 8 +
 rtl/i2s_codec_slave_if.sv | 39 +++
 rtl/i2s_edge_sync.sv | 49 ++++
 rtl/i2s_codec_slave.sv | 163 ++++++++++++++++
 tb/tb_i2s_codec_slave.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the 16-bit left-justified audio serial link.
package audio_pkg;
   localparam int   WORD_BITS_DEF = 16;
   localparam logic CH_LEFT       = 1'b1;
   localparam logic CH_RIGHT      = 1'b0;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} fsm_state_t;
endpackage

// File: rtl/i2s_codec_slave_if.sv
// Serial pins plus the parallel word-side handshake of the codec responder.
interface i2s_codec_slave_if #(
   parameter int WORD_BITS = 16
);
   logic                 AUD_BCLK;
   logic                 AUD_DACLRCK;
   logic                 AUD_DACDAT;
   logic                 AUD_ADCLRCK;
   logic                 AUD_ADCDAT;
   logic [WORD_BITS-1:0] dac_data_l;
   logic [WORD_BITS-1:0] dac_data_r;
   logic                 dac_valid;
   logic                 dac_chan;
   logic [WORD_BITS-1:0] adc_data_l;
   logic [WORD_BITS-1:0] adc_data_r;
   logic                 adc_wr;
   logic                 adc_req;
   logic                 adc_req_chan;
   logic                 frame_err;
   logic                 err_clr;

   modport slave (
      input  AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_ADCLRCK,
      output AUD_ADCDAT,
      output dac_data_l, dac_data_r, dac_valid, dac_chan,
      input  adc_data_l, adc_data_r, adc_wr,
      output adc_req, adc_req_chan, frame_err,
      input  err_clr
   );

   modport master (
      output AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, AUD_ADCLRCK,
      input  AUD_ADCDAT,
      input  dac_data_l, dac_data_r, dac_valid, dac_chan,
      output adc_data_l, adc_data_r, adc_wr,
      input  adc_req, adc_req_chan, frame_err,
      output err_clr
   );
endinterface

// File: rtl/i2s_edge_sync.sv
// Optional synchroniser chain plus previous-level register giving level/rise/fall.
module i2s_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_in,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic                 w_level;
   logic                 r_prev;
   logic [SYNC_STAGES:0] r_arm;

   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign w_level = i_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= i_in;
               for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            end
         end
         assign w_level = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // Edges are masked until the chain and r_prev hold the real pin level,
   // so a pin sitting high at reset release is not mistaken for an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= 1'b0;
         r_arm  <= '0;
      end else begin
         r_prev   <= w_level;
         r_arm[0] <= 1'b1;
         for (int i = 1; i <= SYNC_STAGES; i++) r_arm[i] <= r_arm[i-1];
      end
   end

   assign o_level = w_level;
   assign o_rise  = r_arm[SYNC_STAGES] &  w_level & ~r_prev;
   assign o_fall  = r_arm[SYNC_STAGES] & ~w_level &  r_prev;
endmodule

// File: rtl/i2s_codec_slave.sv
// Codec-side responder: follows external BCLK/LRCK, deserialises DACDAT and
// serialises the held ADC words onto ADCDAT (left-justified, MSB first).
module i2s_codec_slave
   import audio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WORD_BITS   = WORD_BITS_DEF
) (
   input logic              clk,
   input logic              reset,
   i2s_codec_slave_if.slave aud
);
   localparam int            CW   = $clog2(WORD_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

   logic w_bclk_lvl, w_bclk_rise, w_bclk_fall;
   logic w_dlr_lvl, w_dlr_rise, w_dlr_fall, w_dlr_edge;
   logic w_alr_lvl, w_alr_rise, w_alr_fall, w_alr_edge;
   logic w_dat_lvl, w_dat_rise, w_dat_fall;
   logic w_unused;

   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
      .clk(clk), .rst(reset), .i_in(aud.AUD_BCLK),
      .o_level(w_bclk_lvl), .o_rise(w_bclk_rise), .o_fall(w_bclk_fall));
   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dlr (
      .clk(clk), .rst(reset), .i_in(aud.AUD_DACLRCK),
      .o_level(w_dlr_lvl), .o_rise(w_dlr_rise), .o_fall(w_dlr_fall));
   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_alr (
      .clk(clk), .rst(reset), .i_in(aud.AUD_ADCLRCK),
      .o_level(w_alr_lvl), .o_rise(w_alr_rise), .o_fall(w_alr_fall));
   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
      .clk(clk), .rst(reset), .i_in(aud.AUD_DACDAT),
      .o_level(w_dat_lvl), .o_rise(w_dat_rise), .o_fall(w_dat_fall));

   // Only the delayed level of the data pin and the BCLK edges matter.
   assign w_unused   = ^{w_bclk_lvl, w_dat_rise, w_dat_fall};
   assign w_dlr_edge = w_dlr_rise | w_dlr_fall;
   assign w_alr_edge = w_alr_rise | w_alr_fall;

   // ---------------- receive ----------------
   fsm_state_t           r_rx_state, w_rx_state_nxt;
   logic [WORD_BITS-1:0] r_rx_sh, w_rx_sh_nxt;
   logic [CW-1:0]        r_rx_cnt, w_rx_cnt_nxt;
   logic                 r_rx_chan, w_rx_chan_nxt;
   logic                 w_rx_commit, w_err_set;
   logic                 r_rx_commit;
   logic [WORD_BITS-1:0] r_dac_l, r_dac_r;
   logic                 r_dac_valid, r_dac_chan, r_frame_err;

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_sh_nxt    = r_rx_sh;
      w_rx_cnt_nxt   = r_rx_cnt;
      w_rx_chan_nxt  = r_rx_chan;
      w_rx_commit    = 1'b0;
      w_err_set      = 1'b0;
      // LRCK wins over a coincident BCLK rise; that bit opens the new word.
      if (w_dlr_edge) begin
         w_err_set      = (r_rx_state == SHIFT);
         w_rx_state_nxt = SHIFT;
         w_rx_chan_nxt  = w_dlr_lvl;
         w_rx_sh_nxt    = '0;
         w_rx_cnt_nxt   = '0;
         if (w_bclk_rise) begin
            w_rx_sh_nxt  = WORD_BITS'(w_dat_lvl);
            w_rx_cnt_nxt = CW'(1);
         end
      end else if (r_rx_state == SHIFT && w_bclk_rise) begin
         w_rx_sh_nxt  = {r_rx_sh[WORD_BITS-2:0], w_dat_lvl};
         w_rx_cnt_nxt = r_rx_cnt + CW'(1);
         if (r_rx_cnt == LAST) begin
            w_rx_state_nxt = DONE;
            w_rx_commit    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_state  <= IDLE;
         r_rx_sh     <= '0;
         r_rx_cnt    <= '0;
         r_rx_chan   <= 1'b0;
         r_rx_commit <= 1'b0;
         r_dac_l     <= '0;
         r_dac_r     <= '0;
         r_dac_valid <= 1'b0;
         r_dac_chan  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_state  <= w_rx_state_nxt;
         r_rx_sh     <= w_rx_sh_nxt;
         r_rx_cnt    <= w_rx_cnt_nxt;
         r_rx_chan   <= w_rx_chan_nxt;
         r_rx_commit <= w_rx_commit;
         r_dac_valid <= r_rx_commit;
         if (r_rx_commit) begin
            if (r_rx_chan == CH_LEFT) r_dac_l <= r_rx_sh;
            else                      r_dac_r <= r_rx_sh;
            r_dac_chan <= r_rx_chan;
         end
         r_frame_err <= w_err_set | (r_frame_err & ~aud.err_clr);
      end
   end

   // ---------------- transmit ----------------
   fsm_state_t           r_tx_state, w_tx_state_nxt;
   logic [WORD_BITS-1:0] r_tx_sh, w_tx_sh_nxt;
   logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
   logic [WORD_BITS-1:0] r_hold_l, r_hold_r;
   logic                 r_adc_req, r_adc_req_chan;

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_sh_nxt    = r_tx_sh;
      w_tx_cnt_nxt   = r_tx_cnt;
      if (w_alr_edge) begin
         w_tx_state_nxt = SHIFT;
         w_tx_sh_nxt    = (w_alr_lvl == CH_RIGHT) ? r_hold_r : r_hold_l;
         w_tx_cnt_nxt   = '0;
      end else if (r_tx_state == SHIFT && w_bclk_fall) begin
         // LSB stays on the pin for a full bit; the following fall idles it.
         if (r_tx_cnt == LAST) begin
            w_tx_state_nxt = DONE;
            w_tx_sh_nxt    = '0;
         end else begin
            w_tx_sh_nxt  = r_tx_sh << 1;
            w_tx_cnt_nxt = r_tx_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_state     <= IDLE;
         r_tx_sh        <= '0;
         r_tx_cnt       <= '0;
         r_hold_l       <= '0;
         r_hold_r       <= '0;
         r_adc_req      <= 1'b0;
         r_adc_req_chan <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_sh    <= w_tx_sh_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_adc_req  <= w_alr_edge;
         if (w_alr_edge) r_adc_req_chan <= w_alr_lvl;
         if (aud.adc_wr) begin
            r_hold_l <= aud.adc_data_l;
            r_hold_r <= aud.adc_data_r;
         end
      end
   end

   assign aud.AUD_ADCDAT   = r_tx_sh[WORD_BITS-1];
   assign aud.dac_data_l   = r_dac_l;
   assign aud.dac_data_r   = r_dac_r;
   assign aud.dac_valid    = r_dac_valid;
   assign aud.dac_chan     = r_dac_chan;
   assign aud.adc_req      = r_adc_req;
   assign aud.adc_req_chan = r_adc_req_chan;
   assign aud.frame_err    = r_frame_err;
endmodule

// File: tb/tb_i2s_codec_slave.sv
// Bench acting as clock master for two responders (SYNC_STAGES 0 and 2) sharing the same pins.
module tb_i2s_codec_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, bclk, dlrck, ddat, alrck, adc_wr, err_clr;
   logic [15:0] adc_l, adc_r;

   i2s_codec_slave_if #(.WORD_BITS(16)) if0 ();
   i2s_codec_slave_if #(.WORD_BITS(16)) if2 ();

   assign if0.AUD_BCLK = bclk;   assign if2.AUD_BCLK = bclk;
   assign if0.AUD_DACLRCK = dlrck; assign if2.AUD_DACLRCK = dlrck;
   assign if0.AUD_DACDAT = ddat; assign if2.AUD_DACDAT = ddat;
   assign if0.AUD_ADCLRCK = alrck; assign if2.AUD_ADCLRCK = alrck;
   assign if0.adc_data_l = adc_l; assign if2.adc_data_l = adc_l;
   assign if0.adc_data_r = adc_r; assign if2.adc_data_r = adc_r;
   assign if0.adc_wr = adc_wr;   assign if2.adc_wr = adc_wr;
   assign if0.err_clr = err_clr; assign if2.err_clr = err_clr;

   i2s_codec_slave #(.SYNC_STAGES(0), .WORD_BITS(16)) u_dut0 (.clk(clk), .reset(rst), .aud(if0));
   i2s_codec_slave #(.SYNC_STAGES(2), .WORD_BITS(16)) u_dut2 (.clk(clk), .reset(rst), .aud(if2));

   typedef struct packed {logic chan; logic [15:0] data;} dac_exp_t;
   dac_exp_t    q[2][$];
   int          n_chk = 0, n_err = 0;
   bit          en[2];
   int          req_cnt[2];
   logic        cur_lr;
   logic [15:0] model_l, model_r;
   logic [15:0] rx_adc[2];
   logic        tail[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mon(input int id, input logic v, input logic c, input logic [15:0] l,
                      input logic [15:0] r, input logic rq, input logic rqc);
      dac_exp_t e;
      if (!en[id]) return;
      if (v) begin
         if (q[id].size() == 0) chk($sformatf("dac%0d_spurious", id), 32'(v), 32'd0);
         else begin
            e = q[id].pop_front();
            chk($sformatf("dac%0d_chan", id), 32'(c), 32'(e.chan));
            chk($sformatf("dac%0d_data", id), 32'(e.chan ? l : r), 32'(e.data));
         end
      end
      if (rq) begin
         req_cnt[id]++;
         chk($sformatf("adc%0d_req_chan", id), 32'(rqc), 32'(cur_lr));
      end
   endtask

   always @(negedge clk) begin
      mon(0, if0.dac_valid, if0.dac_chan, if0.dac_data_l, if0.dac_data_r, if0.adc_req, if0.adc_req_chan);
      mon(1, if2.dac_valid, if2.dac_chan, if2.dac_data_l, if2.dac_data_r, if2.adc_req, if2.adc_req_chan);
   end

   task automatic do_reset();
      rst = 1'b1;
      model_l = '0;
      model_r = '0;
      tick(3);
      rst = 1'b0;
      tick(4);
   endtask

   task automatic adc_write(input logic [15:0] l, input logic [15:0] r);
      adc_l = l; adc_r = r; adc_wr = 1'b1;
      tick(1);
      adc_wr = 1'b0;
      model_l = l; model_r = r;
   endtask

   // One BCLK period: falling edge (LRCK/data change), then rising edge (master samples ADCDAT).
   task automatic bit_period(input int div, input logic lr, input logic d, input int b);
      bclk = 1'b0; dlrck = lr; alrck = lr; ddat = d;
      tick(div / 2);
      if (b < 16) begin
         rx_adc[0] = {rx_adc[0][14:0], if0.AUD_ADCDAT};
         rx_adc[1] = {rx_adc[1][14:0], if2.AUD_ADCDAT};
      end else begin
         tail[0] = tail[0] | if0.AUD_ADCDAT;
         tail[1] = tail[1] | if2.AUD_ADCDAT;
      end
      bclk = 1'b1;
      tick(div / 2);
   endtask

   task automatic half(input int div, input logic lr, input logic [15:0] w, input int nbits,
                       input int rst_at, input bit chk_adc);
      logic d;
      cur_lr = lr;
      for (int id = 0; id < 2; id++) begin
         rx_adc[id] = '0;
         tail[id]   = 1'b0;
         if (en[id] && nbits >= 16 && rst_at < 0) q[id].push_back({lr, w});
      end
      for (int b = 0; b < nbits; b++) begin
         if (b == rst_at) do_reset();
         d = (b < 16) ? w[15-b] : 1'b0;
         bit_period(div, lr, d, b);
      end
      if (chk_adc)
         for (int id = 0; id < 2; id++)
            if (en[id]) begin
               chk($sformatf("adc%0d_word", id), 32'(rx_adc[id]), 32'(lr ? model_l : model_r));
               if (nbits > 16) chk($sformatf("adc%0d_tail", id), 32'(tail[id]), 32'd0);
            end
   endtask

   task automatic phase_end(input string tag, input int halves);
      tick(40);
      for (int id = 0; id < 2; id++)
         if (en[id]) begin
            chk($sformatf("%s_q%0d_left", tag, id), 32'(q[id].size()), 32'd0);
            chk($sformatf("%s_req%0d_cnt", tag, id), 32'(req_cnt[id]), 32'(halves));
            req_cnt[id] = 0;
         end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] wl, wr;
      rst = 1'b1; bclk = 1'b0; dlrck = 1'b0; ddat = 1'b0; alrck = 1'b0;
      adc_wr = 1'b0; err_clr = 1'b0; adc_l = '0; adc_r = '0;
      model_l = '0; model_r = '0; cur_lr = 1'b0;
      en[0] = 1'b1; en[1] = 1'b1; req_cnt[0] = 0; req_cnt[1] = 0;

      // Reset state with no clock-master activity
      tick(3);
      rst = 1'b0;
      tick(100);
      chk("rst_dac_l", 32'(if0.dac_data_l), 32'd0);
      chk("rst_dac_r", 32'(if0.dac_data_r), 32'd0);
      chk("rst_dac_valid", 32'(if0.dac_valid), 32'd0);
      chk("rst_dac_chan", 32'(if0.dac_chan), 32'd0);
      chk("rst_adc_req", 32'(if0.adc_req), 32'd0);
      chk("rst_req_chan", 32'(if0.adc_req_chan), 32'd0);
      chk("rst_frame_err", 32'(if0.frame_err), 32'd0);
      chk("rst_adcdat", 32'(if0.AUD_ADCDAT), 32'd0);
      chk("rst_dut2_all", {if2.dac_data_l, if2.dac_data_r} | 32'({if2.dac_valid, if2.dac_chan,
          if2.adc_req, if2.adc_req_chan, if2.frame_err, if2.AUD_ADCDAT}), 32'd0);
      chk("rst_no_req", 32'(req_cnt[0] + req_cnt[1]), 32'd0);

      // SYNC_STAGES=0 loopback at BCLK=clk/4, 256-clk frames
      en[1] = 1'b0;
      adc_write(16'h8001, 16'h7FFE);
      for (int f = 0; f < 3; f++) begin
         half(4, 1'b1, 16'h1234, 32, -1, 1'b1);
         half(4, 1'b0, 16'hABCD, 32, -1, 1'b1);
      end
      phase_end("loop", 6);

      // Short word followed by a full one, both responders at clk/16
      do_reset();
      en[1] = 1'b1;
      adc_write(16'hC3A5, 16'h1E0F);
      half(16, 1'b1, 16'hFFFF, 9, -1, 1'b0);
      chk("ferr0_before", 32'(if0.frame_err), 32'd0);
      chk("ferr2_before", 32'(if2.frame_err), 32'd0);
      half(16, 1'b0, 16'h5A5A, 16, -1, 1'b1);
      tick(8);
      chk("ferr0_set", 32'(if0.frame_err), 32'd1);
      chk("ferr2_set", 32'(if2.frame_err), 32'd1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
      chk("ferr0_clr", 32'(if0.frame_err), 32'd0);
      chk("ferr2_clr", 32'(if2.frame_err), 32'd0);
      phase_end("ferr", 2);

      // Reset at bit 7 of a left word; the next right word must arrive intact
      half(16, 1'b1, 16'h9C3E, 16, 7, 1'b0);
      half(16, 1'b0, 16'h6B21, 16, -1, 1'b1);
      chk("rstmid_ferr0", 32'(if0.frame_err), 32'd0);
      chk("rstmid_ferr2", 32'(if2.frame_err), 32'd0);
      phase_end("rstmid", 2);

      // Random words, both responders
      for (int f = 0; f < 64; f++) begin
         adc_write(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
         wl = 16'($urandom_range(0, 65535));
         wr = 16'($urandom_range(0, 65535));
         half(16, 1'b1, wl, 16, -1, 1'b1);
         half(16, 1'b0, wr, 16, -1, 1'b1);
      end
      phase_end("rand", 128);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
